// File: rtl/uart_pkg.sv
// Shared UART definitions used by the TX, RX and buffering stages.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive-buffer bus: receiver write strobe, consumer pop and status flags.
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
);
    uart_byte_t               rx_data;
    logic                     rx_ready;
    logic                     rd_en;
    logic                     ovf_clr;
    uart_byte_t               rd_data;
    logic                     rd_valid;
    logic                     empty;
    logic                     full;
    logic                     almost_full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [7:0]               drop_cnt;

    modport master (
        output rx_data, rx_ready, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, almost_full, count, overflow, drop_cnt
    );

    modport slave (
        input  rx_data, rx_ready, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, almost_full, count, overflow, drop_cnt
    );
endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x byte storage: synchronous write, registered read that holds its value when idle.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  uart_byte_t    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output uart_byte_t    rd_data
);
    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read-before-write: a same-slot write and read (full FIFO) returns the old byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver: edge-detected writes, registered pops, sticky overflow.
// Optional saturating dropped-byte counter built when UART_RX_FIFO_DROPCNT_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_ready_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          empty_q;
    logic          full_q;
    logic          af_q;
    logic          rd_valid_q;
    logic          overflow_q;
    uart_byte_t    rd_byte;

    logic wr_evt;
    logic pop;
    logic push;
    logic drop;

    assign wr_evt = bus.rx_ready & ~rx_ready_q;
    assign pop    = bus.rd_en & ~empty_q;
    // A concurrent pop frees the slot, so a write into a full FIFO is still accepted.
    assign push   = wr_evt & (~full_q | pop);
    assign drop   = wr_evt & full_q & ~pop;

    always_comb begin
        count_nxt = count_q;
        case ({push, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rx_ready_q <= bus.rx_ready;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q    <= count_nxt;
            empty_q    <= (count_nxt == '0);
            full_q     <= (count_nxt == CW'(DEPTH));
            af_q       <= (count_nxt >= CW'(AF_LEVEL));
            rd_valid_q <= pop;
            if (drop)             overflow_q <= 1'b1;
            else if (bus.ovf_clr) overflow_q <= 1'b0;
        end
    end

    uart_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (bus.rx_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (rd_byte)
    );

`ifdef UART_RX_FIFO_DROPCNT_EN
    logic [7:0] drop_q;

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                drop_q <= 8'h00;
        else if (drop && bus.ovf_clr) drop_q <= 8'h01;
        else if (drop)            drop_q <= (drop_q == 8'hFF) ? 8'hFF : drop_q + 8'h01;
        else if (bus.ovf_clr)     drop_q <= 8'h00;
    end

    assign bus.drop_cnt = drop_q;
`else
    assign bus.drop_cnt = 8'h00;
`endif

    assign bus.rd_data     = rd_byte;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.almost_full = af_q;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus random stimulus against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic       prev_rr;
    logic       m_ovf;
    int         m_drops;
    logic [7:0] m_rd_data;
    logic       m_rd_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        prev_rr    = 1'b0;
        m_ovf      = 1'b0;
        m_drops    = 0;
        m_rd_data  = 8'h00;
        m_rd_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int sz;
        sz = q.size();
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(m_rd_valid));
        chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(m_rd_data));
        chk({tag, ".count"}, 32'(bus.count), 32'(sz));
        chk({tag, ".empty"}, 32'(bus.empty), 32'(sz == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(sz == DEPTH));
        chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(sz >= AF));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_DROPCNT_EN
        chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drops));
`else
        chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'h0);
`endif
    endtask

    // One clock cycle: drive inputs, advance the model, check every output after the edge.
    task automatic cyc(input logic rr, input logic [7:0] d, input logic re, input logic clr);
        int  n;
        bit  did_pop;
        bit  dropped;
        bus.rx_ready = rr;
        bus.rx_data  = d;
        bus.rd_en    = re;
        bus.ovf_clr  = clr;
        n       = q.size();
        did_pop = re && (n > 0);
        dropped = 1'b0;
        m_rd_valid = did_pop;
        if (did_pop) m_rd_data = q.pop_front();
        if (rr && !prev_rr) begin
            if (n < DEPTH || did_pop) q.push_back(d);
            else                      dropped = 1'b1;
        end
        prev_rr = rr;
        if (dropped)  m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (dropped)  m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
        else if (clr) m_drops = 0;
        @(posedge clk);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic wr(input logic [7:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
        cyc(1'b0, d, 1'b0, 1'b0);
    endtask

    initial begin
        int next_exp;
        int got;
        reset        = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rd_en    = 1'b0;
        bus.ovf_clr  = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // Ordered write/read of three bytes
        wr(8'hA5); wr(8'h3C); wr(8'hFF);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("pop0", 32'(bus.rd_data), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("pop1", 32'(bus.rd_data), 32'h3C);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("pop2", 32'(bus.rd_data), 32'hFF);
        chk("drained_empty", 32'(bus.empty), 32'h1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("pop_empty_novalid", 32'(bus.rd_valid), 32'h0);

        // A held rx_ready writes exactly once
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h11, 1'b0, 1'b0);
        chk("held_count", 32'(bus.count), 32'h1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("held_byte", 32'(bus.rd_data), 32'h11);

        // Fill through the watermark to full, then overflow
        for (int i = 0; i < 12; i++) begin
            if (i == 11) chk("af_below", 32'(bus.almost_full), 32'h0);
            wr(8'($urandom));
        end
        chk("af_at_12", 32'(bus.almost_full), 32'h1);
        for (int i = 0; i < 4; i++) wr(8'($urandom));
        chk("full_16", 32'(bus.full), 32'h1);
        wr(8'h77);
        chk("ovf_set", 32'(bus.overflow), 32'h1);
        chk("ovf_count", 32'(bus.count), 32'd16);
`ifdef UART_RX_FIFO_DROPCNT_EN
        chk("drop_one", 32'(bus.drop_cnt), 32'h1);
`endif
        // Drop and clear together: set wins, counter restarts at one
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        chk("ovf_setwins", 32'(bus.overflow), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'h0);

        // Write+pop while full
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);
        chk("fullwp_count", 32'(bus.count), 32'd16);
        chk("fullwp_ovf", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fullwp_last", 32'(bus.rd_data), 32'hC3);
        chk("fullwp_empty", 32'(bus.empty), 32'h1);

        // Streaming across pointer wrap
        next_exp = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(i), 1'b1, 1'b0);
            if (bus.rd_valid) begin chk("stream", 32'(bus.rd_data), 32'(next_exp)); next_exp++; end
            cyc(1'b0, 8'(i), 1'b1, 1'b0);
            if (bus.rd_valid) begin chk("stream", 32'(bus.rd_data), 32'(next_exp)); next_exp++; end
        end
        got = next_exp;
        chk("stream_total", 32'(got), 32'd40);
        chk("stream_noovf", 32'(bus.overflow), 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 15) == 0));

        // Asynchronous reset with seven bytes held
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < DEPTH + 2 && q.size() > 0; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) wr(8'($urandom));
        chk("pre_reset_count", 32'(bus.count), 32'd7);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_reset_novalid", 32'(bus.rd_valid), 32'h0);
        wr(8'h5A);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_reset_byte", 32'(bus.rd_data), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each byte the receiver flags on `rx_data`/`rx_ready` and holds it in a circular FIFO. The host logic drains it through a registered pop interface, so a slow consumer does not lose back-to-back received bytes. It reports fill level, an almost-full watermark and a sticky overflow flag.

## Interface
- `DEPTH`, 16: number of byte slots; power of two, >= 2.
- `AF_LEVEL`, 12: `almost_full` asserts when `count >= AF_LEVEL`; range 1..DEPTH.
- `clk` input 1: sole clock; all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `rx_data` input 8: received byte from receiver.
- `rx_ready` input 1: receiver byte-valid; write on its rising edge.
- `rd_en` input 1: pop request from consumer.
- `ovf_clr` input 1: clears `overflow` (and `drop_cnt` when compiled in).
- `rd_data` output 8: popped byte, registered.
- `rd_valid` output 1: one-cycle pulse, `rd_data` valid.
- `empty` output 1: `count == 0`.
- `full` output 1: `count == DEPTH`.
- `almost_full` output 1: watermark flag.
- `count` output $clog2(DEPTH)+1: bytes held.
- `overflow` output 1: sticky; a byte was dropped.
- `drop_cnt` output 8: dropped-byte counter (see Configuration).

## Operation
- Reset values: `rd_data`=8'h00, `rd_valid`=0, `empty`=1, `full`=0, `almost_full`=0, `count`=0, `overflow`=0, `drop_cnt`=0. Pointers=0. Edge-detect register=0.
- Write event: `wr_evt = rx_ready & ~rx_ready_q`. Holding `rx_ready` high writes exactly one byte. `rx_data` is sampled in the same cycle as the rising edge.
- Pointers: `wr_ptr`/`rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` is tracked separately, not derived from the pointers.
- Pop: `rd_en & ~empty` reads slot `rd_ptr` into `rd_data`, pulses `rd_valid` next cycle and advances `rd_ptr`. `rd_en` while empty is ignored: no pulse, `rd_data` holds its value.
- Simultaneous cases:
  - Write+pop, not empty: both happen; `count` unchanged.
  - Write+pop when full: both accepted; no overflow; `count` stays DEPTH.
  - Write+pop when empty: write accepted, pop ignored; no fall-through.
  - Write when full without pop: byte dropped, pointers and `count` unchanged, `overflow` set.
- `ovf_clr`: clears `overflow` next cycle. If a drop occurs in the same cycle, set wins.
- `empty`, `full`, `almost_full` are registered, updated in the same edge as `count`.

## Timing
- Write latency: rising edge of `rx_ready` in cycle N → `count`/`empty` update at edge N+1. Byte poppable from cycle N+1.
- Pop latency: `rd_en` in cycle N → `rd_data`/`rd_valid` valid in cycle N+1, `count` decremented at the same edge.
- Throughput: one pop per cycle. One write per two cycles minimum, because the edge detect needs `rx_ready` low for one cycle.
- Asynchronous reset mid-operation discards contents immediately. The first write after release needs a fresh `rx_ready` rising edge.

## Configuration
- `UART_RX_FIFO_DROPCNT_EN` defined: `drop_cnt` increments on every dropped byte, saturates at 8'hFF, and is cleared by `ovf_clr`. Increment wins over clear in the same cycle, giving 1.
- Undefined: the counter is not built; `drop_cnt` is tied to 8'h00; `overflow` behaviour is unchanged.

## Structure
- Shared package `uart_pkg`: `UART_DATA_W`=8 and the byte typedef, both shared with the TX/RX stages.
- One sub-module: `uart_fifo_ram`, a DEPTH×8 storage array with synchronous write and registered read. The top holds the pointers, count, flags and edge detect.

## Test plan
- Reset, then three writes 8'hA5, 8'h3C, 8'hFF, then three pops → `rd_data` A5, 3C, FF in order, each with a `rd_valid` pulse; then `empty`=1 and `count`=0.
- Hold `rx_ready` high for 5 cycles with `rx_data`=8'h11 → `count`=1 only.
- DEPTH=16, AF_LEVEL=12: write 12 bytes → `almost_full` rises at `count`=12. Write 4 more → `full`=1. A 17th write 8'h77 → dropped, `overflow`=1, `count`=16; with the macro defined, `drop_cnt`=1.
- When full, write and pop in the same cycle → `count` stays 16, `overflow` stays 0, and the new byte is read 16 pops later.
- Write 40 bytes (0..39) while popping continuously → order preserved across pointer wrap, no drops.
- Assert `reset` with `count`=7 → all outputs return to their reset values immediately. `rd_en` after release gives no `rd_valid`.
